// File: rtl/ctrl_pkg.sv
// Purpose: shared control-pipeline types, PCsrc / pc_sel / ALUop codes and helpers.
// Latency: n/a (package only).
// Backpressure: n/a; consumers decide how bundles advance.
package ctrl_pkg;

  localparam int RA_WIDTH  = 5;  // register-address width carried in the bundle
  localparam int AOP_WIDTH = 5;  // ALU opcode width carried in the bundle
  localparam int PCS_WIDTH = 4;  // PCsrc width carried in the bundle

  // Decoder PCsrc codes
  localparam logic [PCS_WIDTH-1:0] PC_SEQ = 4'b0000;
  localparam logic [PCS_WIDTH-1:0] PC_JR  = 4'b0001;
  localparam logic [PCS_WIDTH-1:0] PC_BR  = 4'b0010;
  localparam logic [PCS_WIDTH-1:0] PC_J   = 4'b0011;
  localparam logic [PCS_WIDTH-1:0] PC_JAL = 4'b0111;

  // PC mux select codes driven to the fetch stage
  localparam logic [1:0] SEL_SEQ = 2'd0;
  localparam logic [1:0] SEL_BR  = 2'd1;
  localparam logic [1:0] SEL_JMP = 2'd2;
  localparam logic [1:0] SEL_REG = 2'd3;

  // ALU opcodes
  localparam logic [AOP_WIDTH-1:0] ALU_NOP = 5'd0;
  localparam logic [AOP_WIDTH-1:0] ALU_ADD = 5'd1;
  localparam logic [AOP_WIDTH-1:0] ALU_SUB = 5'd2;
  localparam logic [AOP_WIDTH-1:0] ALU_AND = 5'd3;
  localparam logic [AOP_WIDTH-1:0] ALU_OR  = 5'd4;
  localparam logic [AOP_WIDTH-1:0] ALU_SLT = 5'd5;

  // An all-zero bundle is a bubble: valid=0 and every control deasserted.
  typedef struct packed {
    logic                 valid;
    logic                 regwrite;
    logic                 memtoreg;
    logic                 memread;
    logic                 memwrite;
    logic                 regdst;
    logic                 alusrc;
    logic [PCS_WIDTH-1:0] pcsrc;
    logic [AOP_WIDTH-1:0] aluop;
    logic [RA_WIDTH-1:0]  dest;
  } ctrl_bundle_t;

  // Register write only happens for a live instruction that does not target r0.
  function automatic logic eff_wen(input ctrl_bundle_t b);
    return b.valid & b.regwrite & (b.dest != '0);
  endfunction

  // PC select implied by a PCsrc code; SEL_SEQ means no redirect.
  function automatic logic [1:0] resolve_pc(input logic [PCS_WIDTH-1:0] code,
                                             input logic br_cond);
    logic [1:0] sel;
    sel = SEL_SEQ;
    case (code)
      PC_JR:       sel = SEL_REG;
      PC_BR:       sel = br_cond ? SEL_BR : SEL_SEQ;
      PC_J, PC_JAL: sel = SEL_JMP;
      default:     sel = SEL_SEQ;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// Purpose: one pipeline stage register for a control bundle, with bubble insert.
// Latency: 1 cycle from d to q.
// Backpressure: en=0 holds the stage; bubble=1 loads an all-zero (invalid) bundle.
// Ports: clk, rst_n (async, active-low); en, bubble controls; d next bundle; q held bundle.
module ctrl_stage_reg
  import ctrl_pkg::*;
#(
  parameter type T = ctrl_bundle_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic bubble,
  input  T     d,
  output T     q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= bubble ? '0 : d;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Purpose: carries decoder control through ID/EX, EX/MEM, MEM/WB and resolves jumps/branches in EX.
// Latency: bundle captured at edge N drives EX in N+1, MEM in N+2, WB in N+3; PC resolution is combinational in EX.
// Backpressure: stall_i or redirect turns the ID/EX capture into a bubble; later stages always advance.
// Ports: id_* decoder bundle and rt/rd fields; stall_i from hazard unit; ex_br_cond_i from ALU;
//        ex_*/mem_*/wb_* per-stage controls and destinations; redirect_o/pc_sel_o/flush_o to fetch;
//        flush_cnt_o saturating redirect count.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = RA_WIDTH,
  parameter int ALUOP_W    = AOP_WIDTH,
  parameter int PCSRC_W    = PCS_WIDTH,
  parameter int LINK_REG   = 31,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid_i,
  input  logic                  id_regwrite_i,
  input  logic                  id_memtoreg_i,
  input  logic                  id_memread_i,
  input  logic                  id_memwrite_i,
  input  logic                  id_regdst_i,
  input  logic                  id_alusrc_i,
  input  logic [PCSRC_W-1:0]    id_pcsrc_i,
  input  logic [ALUOP_W-1:0]    id_aluop_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  stall_i,
  input  logic                  ex_br_cond_i,
  output logic [ALUOP_W-1:0]    ex_aluop_o,
  output logic                  ex_alusrc_o,
  output logic                  ex_memread_o,
  output logic [REG_ADDR_W-1:0] ex_dest_o,
  output logic                  ex_wen_o,
  output logic                  mem_memread_o,
  output logic                  mem_memwrite_o,
  output logic [REG_ADDR_W-1:0] mem_dest_o,
  output logic                  mem_wen_o,
  output logic                  wb_regwrite_o,
  output logic                  wb_memtoreg_o,
  output logic                  wb_link_o,
  output logic [REG_ADDR_W-1:0] wb_waddr_o,
  output logic                  redirect_o,
  output logic [1:0]            pc_sel_o,
  output logic                  flush_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  ctrl_bundle_t id_b, ex_q, mem_q, wb_q;
  logic [1:0]   ex_sel;
  logic         redirect;
  logic [CNT_W-1:0] cnt_q;

  // Destination is fixed at ID/EX capture so later stages only carry one address.
  always_comb begin
    id_b          = '0;
    id_b.valid    = id_valid_i;
    id_b.regwrite = id_regwrite_i;
    id_b.memtoreg = id_memtoreg_i;
    id_b.memread  = id_memread_i;
    id_b.memwrite = id_memwrite_i;
    id_b.regdst   = id_regdst_i;
    id_b.alusrc   = id_alusrc_i;
    id_b.pcsrc    = id_pcsrc_i;
    id_b.aluop    = id_aluop_i;
    if (id_pcsrc_i == PC_JAL) begin
      id_b.dest = REG_ADDR_W'(LINK_REG);
    end else if (id_regdst_i) begin
      id_b.dest = id_rt_i;
    end else begin
      id_b.dest = id_rd_i;
    end
  end

  // A redirect squashes the ID instruction, which also covers a coincident stall.
  ctrl_stage_reg u_id_ex (
    .clk(clk), .rst_n(rst_n), .en(1'b1),
    .bubble(redirect | stall_i | ~id_valid_i),
    .d(id_b), .q(ex_q)
  );

  // The redirecting instruction itself moves on, so jal still reaches writeback.
  ctrl_stage_reg u_ex_mem (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .bubble(1'b0),
    .d(ex_q), .q(mem_q)
  );

  ctrl_stage_reg u_mem_wb (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .bubble(1'b0),
    .d(mem_q), .q(wb_q)
  );

  always_comb begin
    ex_sel   = resolve_pc(ex_q.pcsrc, ex_br_cond_i);
    redirect = ex_q.valid & (ex_sel != SEL_SEQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (redirect && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign ex_aluop_o     = ex_q.valid ? ex_q.aluop : '0;
  assign ex_alusrc_o    = ex_q.valid & ex_q.alusrc;
  assign ex_memread_o   = ex_q.valid & ex_q.memread;
  assign ex_dest_o      = ex_q.valid ? ex_q.dest : '0;
  assign ex_wen_o       = eff_wen(ex_q);

  assign mem_memread_o  = mem_q.valid & mem_q.memread;
  assign mem_memwrite_o = mem_q.valid & mem_q.memwrite;
  assign mem_dest_o     = mem_q.valid ? mem_q.dest : '0;
  assign mem_wen_o      = eff_wen(mem_q);

  assign wb_regwrite_o  = eff_wen(wb_q);
  assign wb_memtoreg_o  = wb_q.valid & wb_q.memtoreg;
  assign wb_link_o      = wb_q.valid & (wb_q.pcsrc == PC_JAL);
  assign wb_waddr_o     = wb_q.valid ? wb_q.dest : '0;

  assign redirect_o     = redirect;
  assign flush_o        = redirect;
  assign pc_sel_o       = redirect ? ex_sel : SEL_SEQ;
  assign flush_cnt_o    = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
module tb_ctrl_pipe;
  import ctrl_pkg::*;

  localparam int TB_CNT_W = 10;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic id_valid_i, id_regwrite_i, id_memtoreg_i, id_memread_i, id_memwrite_i;
  logic id_regdst_i, id_alusrc_i;
  logic [3:0] id_pcsrc_i;
  logic [4:0] id_aluop_i, id_rt_i, id_rd_i;
  logic stall_i, ex_br_cond_i;
  logic [4:0] ex_aluop_o, ex_dest_o, mem_dest_o, wb_waddr_o;
  logic ex_alusrc_o, ex_memread_o, ex_wen_o, mem_memread_o, mem_memwrite_o, mem_wen_o;
  logic wb_regwrite_o, wb_memtoreg_o, wb_link_o, redirect_o, flush_o;
  logic [1:0] pc_sel_o;
  logic [TB_CNT_W-1:0] flush_cnt_o;

  int errors = 0;
  int checks = 0;

  ctrl_pipe #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid_i), .id_regwrite_i(id_regwrite_i), .id_memtoreg_i(id_memtoreg_i),
    .id_memread_i(id_memread_i), .id_memwrite_i(id_memwrite_i), .id_regdst_i(id_regdst_i),
    .id_alusrc_i(id_alusrc_i), .id_pcsrc_i(id_pcsrc_i), .id_aluop_i(id_aluop_i),
    .id_rt_i(id_rt_i), .id_rd_i(id_rd_i), .stall_i(stall_i), .ex_br_cond_i(ex_br_cond_i),
    .ex_aluop_o(ex_aluop_o), .ex_alusrc_o(ex_alusrc_o), .ex_memread_o(ex_memread_o),
    .ex_dest_o(ex_dest_o), .ex_wen_o(ex_wen_o), .mem_memread_o(mem_memread_o),
    .mem_memwrite_o(mem_memwrite_o), .mem_dest_o(mem_dest_o), .mem_wen_o(mem_wen_o),
    .wb_regwrite_o(wb_regwrite_o), .wb_memtoreg_o(wb_memtoreg_o), .wb_link_o(wb_link_o),
    .wb_waddr_o(wb_waddr_o), .redirect_o(redirect_o), .pc_sel_o(pc_sel_o),
    .flush_o(flush_o), .flush_cnt_o(flush_cnt_o)
  );

  typedef struct {
    logic       valid, regwrite, memtoreg, memread, memwrite, regdst, alusrc;
    logic [3:0] pcsrc;
    logic [4:0] aluop, rt, rd;
  } instr_t;

  function automatic instr_t mk(input logic v, rw, mtr, mr, mw, rdst, asrc,
                                input logic [3:0] pcs, input logic [4:0] aop, rt, rd);
    instr_t i;
    i.valid = v; i.regwrite = rw; i.memtoreg = mtr; i.memread = mr; i.memwrite = mw;
    i.regdst = rdst; i.alusrc = asrc; i.pcsrc = pcs; i.aluop = aop; i.rt = rt; i.rd = rd;
    return i;
  endfunction

  function automatic instr_t nop();
    return mk(0, 0, 0, 0, 0, 0, 0, 4'd0, 5'd0, 5'd0, 5'd0);
  endfunction

  // Reference rules: where an instruction writes and whether it writes at all.
  function automatic logic [4:0] m_dest(input instr_t i);
    if (i.pcsrc == 4'b0111) return 5'd31;
    return i.regdst ? i.rt : i.rd;
  endfunction

  function automatic logic m_wen(input instr_t i);
    return i.valid && i.regwrite && (m_dest(i) != 5'd0);
  endfunction

  task automatic drive(input instr_t i, input logic stall, input logic brc);
    id_valid_i = i.valid; id_regwrite_i = i.regwrite; id_memtoreg_i = i.memtoreg;
    id_memread_i = i.memread; id_memwrite_i = i.memwrite; id_regdst_i = i.regdst;
    id_alusrc_i = i.alusrc; id_pcsrc_i = i.pcsrc; id_aluop_i = i.aluop;
    id_rt_i = i.rt; id_rd_i = i.rd; stall_i = stall; ex_br_cond_i = brc;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(nop(), 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(mk(1, 1, 1, 1, 1, 1, 1, 4'b0011, 5'd9, 5'd7, 5'd6), 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({ex_aluop_o, ex_alusrc_o, ex_memread_o, ex_dest_o, ex_wen_o, mem_memread_o,
         mem_memwrite_o, mem_dest_o, mem_wen_o, wb_regwrite_o, wb_memtoreg_o, wb_link_o,
         wb_waddr_o, redirect_o, pc_sel_o, flush_o} !== '0)
      begin errors++; $display("FAIL reset_outputs: some output nonzero while rst_n low, required all zero"); end
    checks++;
    if (flush_cnt_o !== '0) begin errors++; $display("FAIL reset_cnt: got %0d required 0", flush_cnt_o); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_addi();
    do_reset();
    drive(mk(1, 1, 0, 0, 0, 0, 0, PC_SEQ, ALU_ADD, 5'd2, 5'd5), 0, 0);
    @(negedge clk); drive(mk(1, 1, 0, 0, 0, 1, 1, PC_SEQ, ALU_ADD, 5'd7, 5'd0), 0, 0); #1;
    checks++;
    if (ex_wen_o !== 1'b1 || ex_dest_o !== 5'd5 || ex_aluop_o !== ALU_ADD)
      begin errors++; $display("FAIL add_ex: wen=%0d dest=%0d aluop=%0d required 1/5/1", ex_wen_o, ex_dest_o, ex_aluop_o); end
    @(negedge clk); drive(mk(1, 1, 0, 0, 0, 0, 0, PC_SEQ, ALU_OR, 5'd4, 5'd0), 0, 0); #1;
    checks++;
    if (mem_dest_o !== 5'd5 || mem_wen_o !== 1'b1)
      begin errors++; $display("FAIL add_mem: dest=%0d wen=%0d required 5/1", mem_dest_o, mem_wen_o); end
    checks++;
    if (ex_dest_o !== 5'd7 || ex_alusrc_o !== 1'b1)
      begin errors++; $display("FAIL addi_ex: dest=%0d alusrc=%0d required 7/1", ex_dest_o, ex_alusrc_o); end
    @(negedge clk); drive(nop(), 0, 0); #1;
    checks++;
    if (wb_regwrite_o !== 1'b1 || wb_waddr_o !== 5'd5 || wb_link_o !== 1'b0)
      begin errors++; $display("FAIL add_wb: regwrite=%0d waddr=%0d link=%0d required 1/5/0", wb_regwrite_o, wb_waddr_o, wb_link_o); end
    checks++;
    if (ex_wen_o !== 1'b0)
      begin errors++; $display("FAIL r0_ex_wen: got %0d required 0", ex_wen_o); end
    @(negedge clk); #1;
    checks++;
    if (wb_regwrite_o !== 1'b1 || wb_waddr_o !== 5'd7)
      begin errors++; $display("FAIL addi_wb: regwrite=%0d waddr=%0d required 1/7", wb_regwrite_o, wb_waddr_o); end
    @(negedge clk); #1;
    checks++;
    if (wb_regwrite_o !== 1'b0)
      begin errors++; $display("FAIL r0_wb: regwrite=%0d required 0", wb_regwrite_o); end
  endtask

  task automatic test_branch();
    do_reset();
    drive(mk(1, 0, 0, 0, 0, 0, 0, PC_BR, ALU_SUB, 5'd1, 5'd0), 0, 0);
    @(negedge clk); drive(mk(1, 1, 0, 0, 0, 0, 0, PC_SEQ, ALU_ADD, 5'd0, 5'd9), 0, 1); #1;
    checks++;
    if (redirect_o !== 1'b1 || pc_sel_o !== 2'd1 || flush_o !== 1'b1)
      begin errors++; $display("FAIL beq_taken: redirect=%0d sel=%0d flush=%0d required 1/1/1", redirect_o, pc_sel_o, flush_o); end
    @(negedge clk); drive(nop(), 0, 0); #1;
    checks++;
    if (ex_wen_o !== 1'b0 || ex_aluop_o !== 5'd0 || ex_dest_o !== 5'd0 || redirect_o !== 1'b0)
      begin errors++; $display("FAIL beq_bubble: wen=%0d aluop=%0d dest=%0d redirect=%0d required all 0", ex_wen_o, ex_aluop_o, ex_dest_o, redirect_o); end
    checks++;
    if (flush_cnt_o !== 10'd1) begin errors++; $display("FAIL beq_cnt: got %0d required 1", flush_cnt_o); end
    @(negedge clk); drive(mk(1, 0, 0, 0, 0, 0, 0, PC_BR, ALU_SUB, 5'd1, 5'd0), 0, 0);
    @(negedge clk); drive(mk(1, 1, 0, 0, 0, 0, 0, PC_SEQ, ALU_ADD, 5'd0, 5'd9), 0, 0); #1;
    checks++;
    if (redirect_o !== 1'b0 || pc_sel_o !== 2'd0 || flush_o !== 1'b0)
      begin errors++; $display("FAIL beq_not_taken: redirect=%0d sel=%0d flush=%0d required 0/0/0", redirect_o, pc_sel_o, flush_o); end
    @(negedge clk); drive(nop(), 0, 0); #1;
    checks++;
    if (ex_wen_o !== 1'b1 || ex_dest_o !== 5'd9 || flush_cnt_o !== 10'd1)
      begin errors++; $display("FAIL beq_fallthrough: wen=%0d dest=%0d cnt=%0d required 1/9/1", ex_wen_o, ex_dest_o, flush_cnt_o); end
  endtask

  task automatic test_jal();
    do_reset();
    drive(mk(1, 1, 0, 0, 0, 0, 0, PC_JAL, ALU_NOP, 5'd2, 5'd3), 0, 0);
    @(negedge clk); drive(nop(), 0, 0); #1;
    checks++;
    if (redirect_o !== 1'b1 || pc_sel_o !== 2'd2 || ex_dest_o !== 5'd31)
      begin errors++; $display("FAIL jal_ex: redirect=%0d sel=%0d dest=%0d required 1/2/31", redirect_o, pc_sel_o, ex_dest_o); end
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (wb_regwrite_o !== 1'b1 || wb_link_o !== 1'b1 || wb_waddr_o !== 5'd31)
      begin errors++; $display("FAIL jal_wb: regwrite=%0d link=%0d waddr=%0d required 1/1/31", wb_regwrite_o, wb_link_o, wb_waddr_o); end
  endtask

  task automatic test_stall();
    do_reset();
    drive(mk(1, 1, 1, 1, 0, 1, 1, PC_SEQ, ALU_ADD, 5'd8, 5'd0), 0, 0);
    @(negedge clk); drive(mk(1, 1, 0, 0, 0, 0, 0, PC_SEQ, ALU_ADD, 5'd8, 5'd10), 1, 0); #1;
    checks++;
    if (ex_memread_o !== 1'b1 || ex_dest_o !== 5'd8)
      begin errors++; $display("FAIL lw_ex: memread=%0d dest=%0d required 1/8", ex_memread_o, ex_dest_o); end
    @(negedge clk); drive(mk(1, 1, 0, 0, 0, 0, 0, PC_SEQ, ALU_ADD, 5'd8, 5'd10), 0, 0); #1;
    checks++;
    if (ex_wen_o !== 1'b0 || ex_aluop_o !== 5'd0 || ex_memread_o !== 1'b0)
      begin errors++; $display("FAIL stall_bubble: wen=%0d aluop=%0d memread=%0d required 0/0/0", ex_wen_o, ex_aluop_o, ex_memread_o); end
    checks++;
    if (mem_memread_o !== 1'b1 || mem_dest_o !== 5'd8)
      begin errors++; $display("FAIL lw_mem: memread=%0d dest=%0d required 1/8", mem_memread_o, mem_dest_o); end
    @(negedge clk); drive(nop(), 0, 0); #1;
    checks++;
    if (ex_dest_o !== 5'd10 || ex_wen_o !== 1'b1 || wb_memtoreg_o !== 1'b1 || wb_waddr_o !== 5'd8)
      begin errors++; $display("FAIL stall_resume: exdest=%0d exwen=%0d mtr=%0d waddr=%0d required 10/1/1/8", ex_dest_o, ex_wen_o, wb_memtoreg_o, wb_waddr_o); end
    @(negedge clk); drive(mk(1, 0, 0, 0, 0, 0, 0, PC_JR, ALU_NOP, 5'd0, 5'd0), 0, 0);
    @(negedge clk); drive(mk(1, 1, 0, 0, 0, 0, 0, PC_SEQ, ALU_ADD, 5'd0, 5'd11), 1, 0); #1;
    checks++;
    if (redirect_o !== 1'b1 || pc_sel_o !== 2'd3)
      begin errors++; $display("FAIL jr_stall: redirect=%0d sel=%0d required 1/3", redirect_o, pc_sel_o); end
    @(negedge clk); drive(mk(1, 1, 0, 0, 0, 0, 0, PC_SEQ, ALU_ADD, 5'd0, 5'd12), 0, 0); #1;
    checks++;
    if (ex_wen_o !== 1'b0 || ex_aluop_o !== 5'd0 || redirect_o !== 1'b0)
      begin errors++; $display("FAIL jr_bubble: wen=%0d aluop=%0d redirect=%0d required 0/0/0", ex_wen_o, ex_aluop_o, redirect_o); end
    @(negedge clk); drive(nop(), 0, 0); #1;
    checks++;
    if (ex_dest_o !== 5'd12 || ex_wen_o !== 1'b1)
      begin errors++; $display("FAIL jr_single_bubble: dest=%0d wen=%0d required 12/1", ex_dest_o, ex_wen_o); end
  endtask

  // Timeline model: the instruction in EX/MEM/WB this cycle is whatever ID/EX
  // captured one/two/three edges ago.
  task automatic test_random();
    instr_t hist[$];
    instr_t ins, ex, mem, wb;
    logic stall, brc, redir;
    logic [1:0] sel;
    int cnt;
    logic [12:0] exp_ex, got_ex;
    logic [7:0] exp_mem, got_mem, exp_wb, got_wb;
    int r;
    do_reset();
    cnt = 0;
    repeat (3) hist.push_back(nop());
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      ins = mk(($urandom_range(0, 7) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 1),
               (r < 5) ? 4'd0 : (r == 5) ? 4'd1 : (r == 6) ? 4'd2 : (r == 7) ? 4'd3 :
               (r == 8) ? 4'd7 : 4'($urandom_range(0, 15)),
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 31)),
               5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 31)));
      stall = ($urandom_range(0, 4) == 0);
      brc = $urandom_range(0, 1);
      drive(ins, stall, brc);
      #1;
      ex = hist[2]; mem = hist[1]; wb = hist[0];
      sel = 2'd0;
      if (ex.valid) begin
        if (ex.pcsrc == 4'd1) sel = 2'd3;
        else if (ex.pcsrc == 4'd2 && brc) sel = 2'd1;
        else if (ex.pcsrc == 4'd3 || ex.pcsrc == 4'd7) sel = 2'd2;
      end
      redir = (sel != 2'd0);
      exp_ex = ex.valid ? {ex.aluop, ex.alusrc, ex.memread, m_dest(ex), m_wen(ex)} : '0;
      got_ex = {ex_aluop_o, ex_alusrc_o, ex_memread_o, ex_dest_o, ex_wen_o};
      exp_mem = mem.valid ? {mem.memread, mem.memwrite, m_dest(mem), m_wen(mem)} : '0;
      got_mem = {mem_memread_o, mem_memwrite_o, mem_dest_o, mem_wen_o};
      exp_wb = wb.valid ? {m_wen(wb), wb.memtoreg, (wb.pcsrc == 4'd7), m_dest(wb)} : '0;
      got_wb = {wb_regwrite_o, wb_memtoreg_o, wb_link_o, wb_waddr_o};
      checks++;
      if (got_ex !== exp_ex) begin errors++; $display("FAIL rnd_ex cyc %0d: got %h required %h", n, got_ex, exp_ex); end
      checks++;
      if (got_mem !== exp_mem) begin errors++; $display("FAIL rnd_mem cyc %0d: got %h required %h", n, got_mem, exp_mem); end
      checks++;
      if (got_wb !== exp_wb) begin errors++; $display("FAIL rnd_wb cyc %0d: got %h required %h", n, got_wb, exp_wb); end
      checks++;
      if ({redirect_o, flush_o, pc_sel_o} !== {redir, redir, sel})
        begin errors++; $display("FAIL rnd_pc cyc %0d: redirect=%0d flush=%0d sel=%0d required %0d/%0d/%0d", n, redirect_o, flush_o, pc_sel_o, redir, redir, sel); end
      checks++;
      if (int'(flush_cnt_o) != cnt) begin errors++; $display("FAIL rnd_cnt cyc %0d: got %0d required %0d", n, flush_cnt_o, cnt); end
      void'(hist.pop_front());
      hist.push_back((redir || stall || !ins.valid) ? nop() : ins);
      if (redir && cnt < CNT_MAX) cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_saturation_and_async_reset();
    instr_t j;
    logic ex_is_j;
    int cnt;
    j = mk(1, 0, 0, 0, 0, 0, 1, PC_J, ALU_ADD, 5'd0, 5'd0);
    do_reset();
    cnt = 0;
    ex_is_j = 1'b0;
    for (int k = 0; k < 2 * CNT_MAX + 40; k++) begin
      drive(j, 0, 0);
      #1;
      if (k == 201) begin
        checks++;
        if (int'(flush_cnt_o) != cnt) begin errors++; $display("FAIL sat_mid: got %0d required %0d", flush_cnt_o, cnt); end
      end
      if (ex_is_j && cnt < CNT_MAX) cnt++;
      ex_is_j = !ex_is_j;
      @(negedge clk);
    end
    drive(j, 0, 0);
    #1;
    checks++;
    if (int'(flush_cnt_o) != CNT_MAX || cnt != CNT_MAX)
      begin errors++; $display("FAIL sat_cnt: got %0d required %0d", flush_cnt_o, CNT_MAX); end
    if (!ex_is_j) begin @(negedge clk); drive(j, 0, 0); #1; end
    checks++;
    if (redirect_o !== 1'b1 || ex_aluop_o !== ALU_ADD)
      begin errors++; $display("FAIL sat_live: redirect=%0d aluop=%0d required 1/1", redirect_o, ex_aluop_o); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ex_aluop_o, ex_alusrc_o, ex_memread_o, ex_dest_o, ex_wen_o, mem_memread_o,
         mem_memwrite_o, mem_dest_o, mem_wen_o, wb_regwrite_o, wb_memtoreg_o, wb_link_o,
         wb_waddr_o, redirect_o, pc_sel_o, flush_o} !== '0)
      begin errors++; $display("FAIL async_reset_outputs: outputs nonzero right after rst_n fell, required all zero"); end
    checks++;
    if (flush_cnt_o !== '0) begin errors++; $display("FAIL async_reset_cnt: got %0d required 0", flush_cnt_o); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add_addi();
    test_branch();
    test_jal();
    test_stall();
    test_random();
    test_saturation_and_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
